// File: rtl/wbpwm_pkg.sv
// Shared definitions for the Wishbone PWM audio receiver.
// Holds the register map (addresses and bit positions), the smallest legal
// frame length, the layout of the data register and small helper functions
// used by the top level.
package wbpwm_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int VALID_BIT   = 16;
  localparam int OVERRUN_BIT = 17;
  localparam int ENABLE_BIT  = 31;

  localparam logic [15:0] MIN_FRAME_LEN = 16'd2;

  // Read layout of the data register at address 0.
  typedef struct packed {
    logic [13:0] pad;
    logic        overrun;
    logic        valid;
    logic [15:0] sample;
  } data_word_t;

  // Clamp a 17-bit signed difference into the signed 16-bit sample range.
  function automatic logic [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      return 16'h7FFF;
    end else if (v < -17'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // A frame needs at least two clocks so that the midpoint is nonzero.
  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    return (len < MIN_FRAME_LEN) ? MIN_FRAME_LEN : len;
  endfunction

endpackage

// File: rtl/wbpwm_capture_if.sv
// Wishbone slave bus bundle for wbpwm_capture.
// Signals: i_wb_cyc/i_wb_stb/i_wb_we/i_wb_addr/i_wb_data driven by the bus
// master; o_wb_ack/o_wb_stall/o_wb_data driven by the peripheral.
interface wbpwm_capture_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic        i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/pwm_frame_counter.sv
// Frame timer and high-clock accumulator for the PWM receiver.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   pwm            raw asynchronous PWM line
//   enable         run the frame timer; when low the frame is held at its start
//   frame_len      current frame length in clocks
//   restart        start a fresh frame of restart_len clocks, dropping any
//                  result not yet consumed
//   restart_len    length used for the restarted frame
//   h_reg          high-clock count of the last completed frame
//   h_stb          one-cycle pulse when h_reg holds a new count
module pwm_frame_counter #(
  parameter logic [15:0] DEFAULT_FRAME_LEN = 16'd1814,
  parameter int          TIMING_BITS       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pwm,
  input  logic                   enable,
  input  logic [TIMING_BITS-1:0] frame_len,
  input  logic                   restart,
  input  logic [TIMING_BITS-1:0] restart_len,
  output logic [TIMING_BITS-1:0] h_reg,
  output logic                   h_stb
);

  logic                   s1;
  logic                   p_s;
  logic [TIMING_BITS-1:0] timer;
  logic [TIMING_BITS-1:0] high_count;

  // Two-flop synchronizer for the asynchronous PWM line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      p_s <= 1'b0;
    end else begin
      s1  <= pwm;
      p_s <= s1;
    end
  end

  // The frame ends on the cycle where the timer reads zero; that cycle's
  // sample is folded into the result so every frame covers exactly
  // frame_len synchronized samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= DEFAULT_FRAME_LEN - 16'd1;
      high_count <= '0;
      h_reg      <= '0;
      h_stb      <= 1'b0;
    end else if (restart) begin
      timer      <= restart_len - 1'b1;
      high_count <= '0;
      h_stb      <= 1'b0;
    end else if (!enable) begin
      timer      <= frame_len - 1'b1;
      high_count <= '0;
      h_stb      <= 1'b0;
    end else if (timer == '0) begin
      timer      <= frame_len - 1'b1;
      h_reg      <= high_count + {{(TIMING_BITS-1){1'b0}}, p_s};
      high_count <= '0;
      h_stb      <= 1'b1;
    end else begin
      timer      <= timer - 1'b1;
      high_count <= high_count + {{(TIMING_BITS-1){1'b0}}, p_s};
      h_stb      <= 1'b0;
    end
  end

endmodule

// File: rtl/wbpwm_capture.sv
// Wishbone-controlled PWM audio receiver.
// Counts the high clocks of an external PWM line over fixed frames, turns
// each count into a signed 16-bit sample centred on the frame midpoint and
// holds it in a one-deep buffer with valid/overrun flags.
// Ports:
//   i_clk, i_reset_n  clock and asynchronous active-low reset
//   wb                Wishbone slave bundle (address 0 data, address 1 control)
//   i_pwm             asynchronous PWM input
//   o_int             sample-ready interrupt, high while a sample is unread
module wbpwm_capture
  import wbpwm_pkg::*;
#(
  parameter logic [15:0] DEFAULT_FRAME_LEN = 16'd1814,
  parameter int          TIMING_BITS       = 16,
  parameter int          VARIABLE_RATE     = 0
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  wbpwm_capture_if.slave  wb,
  input  logic            i_pwm,
  output logic            o_int
);

  logic [15:0]        frame_len;
  logic [15:0]        sample;
  logic               valid;
  logic               overrun;
  logic               enable;
  logic [15:0]        h_reg;
  logic               h_stb;
  logic               rd_data;
  logic               wr_data;
  logic               wr_ctrl;
  logic               restart;
  logic               convert;
  logic [15:0]        new_len;
  logic signed [16:0] diff;
  data_word_t         status;
  logic [31:0]        ctrl_word;
  logic               unused_bits;

  assign rd_data = wb.i_wb_stb && !wb.i_wb_we && (wb.i_wb_addr == ADDR_DATA);
  assign wr_data = wb.i_wb_stb &&  wb.i_wb_we && (wb.i_wb_addr == ADDR_DATA);
  assign wr_ctrl = wb.i_wb_stb &&  wb.i_wb_we && (wb.i_wb_addr == ADDR_CTRL);

  // A length write restarts the frame and takes priority over a frame result
  // arriving in the same cycle, which is simply discarded.
  assign restart = wr_ctrl && (VARIABLE_RATE != 0);
  assign new_len = clamp_len(wb.i_wb_data[15:0]);
  assign convert = h_stb && !restart;

  assign diff = $signed({1'b0, h_reg}) - $signed({2'b00, frame_len[15:1]});

  assign status    = '{pad: 14'h0, overrun: overrun, valid: valid, sample: sample};
  assign ctrl_word = {enable, 15'h0, frame_len};

  assign wb.o_wb_stall = 1'b0;
  assign o_int         = valid;

  assign unused_bits = &{1'b0, wb.i_wb_cyc, wb.i_wb_data[30:18], wb.i_wb_data[16]};

  pwm_frame_counter #(
    .DEFAULT_FRAME_LEN (DEFAULT_FRAME_LEN),
    .TIMING_BITS       (TIMING_BITS)
  ) u_counter (
    .clk         (i_clk),
    .rst_n       (i_reset_n),
    .pwm         (i_pwm),
    .enable      (enable),
    .frame_len   (frame_len),
    .restart     (restart),
    .restart_len (new_len),
    .h_reg       (h_reg),
    .h_stb       (h_stb)
  );

  // Control register: enable always writable, length only in variable-rate builds.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      enable    <= 1'b1;
      frame_len <= DEFAULT_FRAME_LEN;
    end else if (wr_ctrl) begin
      enable <= wb.i_wb_data[ENABLE_BIT];
      if (restart) begin
        frame_len <= new_len;
      end
    end
  end

  // Sample buffer. A conversion beats a pop landing in the same cycle, and
  // an overrun set beats a clear-write in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sample  <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (convert) begin
        sample <= sat16(diff);
        valid  <= 1'b1;
      end else if (rd_data) begin
        valid <= 1'b0;
      end
      if (convert && valid && !rd_data) begin
        overrun <= 1'b1;
      end else if (wr_data && wb.i_wb_data[OVERRUN_BIT]) begin
        overrun <= 1'b0;
      end
    end
  end

  // Bus response: ack follows strobe by one clock, read data captured with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wb.o_wb_ack  <= 1'b0;
      wb.o_wb_data <= '0;
    end else begin
      wb.o_wb_ack <= wb.i_wb_stb;
      if (wb.i_wb_stb) begin
        wb.o_wb_data <= (wb.i_wb_addr == ADDR_CTRL) ? ctrl_word : status;
      end
    end
  end

endmodule

// File: tb/tb_wbpwm_capture.sv
// Self-checking bench for wbpwm_capture (frame length 100, variable rate).
// The PWM line is driven every cycle from a selectable pattern and logged;
// expected samples are computed from that log by summing the synchronized
// line over each frame window and centring on the frame midpoint.
module tb_wbpwm_capture;

  localparam int L0 = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic pwm   = 1'b0;
  logic o_int;

  wbpwm_capture_if bus();

  wbpwm_capture #(
    .DEFAULT_FRAME_LEN (16'd100),
    .TIMING_BITS       (16),
    .VARIABLE_RATE     (1)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .wb        (bus.slave),
    .i_pwm     (pwm),
    .o_int     (o_int)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int base       = 0;
  int sync_base  = 0;
  int cur_len    = L0;
  int mode       = 0;
  bit hist [0:99999];

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // PWM pattern for the cycle about to start: 0 low, 1 high,
  // 2 half-high aligned to the current frame, otherwise random.
  function automatic bit next_pwm();
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((cyc - base) % cur_len) < (cur_len / 2);
      default: return bit'($urandom_range(0, 1));
    endcase
  endfunction

  // Advance one clock and drive the PWM value for the new cycle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
    pwm = next_pwm();
    hist[cyc] = pwm;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) applyStimulus();
  endtask

  // The counter sees the line two clocks late; nothing before reset release.
  function automatic int ps_at(input int c);
    int k;
    k = c - 2;
    return (k >= sync_base) ? int'(hist[k]) : 0;
  endfunction

  function automatic logic [15:0] exp_sample(input int start, input int len);
    int h;
    int d;
    h = 0;
    for (int c = start; c < start + len; c++) h += ps_at(c);
    d = h - (len / 2);
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d[15:0];
  endfunction

  function automatic logic [31:0] dword(input bit ovr, input bit vld, input logic [15:0] s);
    return {14'h0, ovr, vld, s};
  endfunction

  // First cycle in which the sample of frame f is readable.
  function automatic int rdy(input int f);
    return base + (f + 1) * cur_len + 1;
  endfunction

  function automatic int fs(input int f);
    return base + f * cur_len;
  endfunction

  task automatic read_reg(input logic addr, output logic [31:0] d);
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = addr;
    applyStimulus();
    d = bus.o_wb_data;
    checkOutput("ack", {31'h0, bus.o_wb_ack}, 32'h1);
    bus.i_wb_stb = 1'b0;
  endtask

  task automatic write_reg(input logic addr, input logic [31:0] data);
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
    applyStimulus();
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
  endtask

  initial begin : watchdog
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [31:0] d;
    logic [15:0] s6;
    int w;
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 1'b0;
    bus.i_wb_data = 32'h0;

    #2 rst_n = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("reset_int", {31'h0, o_int}, 32'h0);
    checkOutput("reset_ack", {31'h0, bus.o_wb_ack}, 32'h0);
    checkOutput("reset_data", bus.o_wb_data, 32'h0);
    checkOutput("reset_stall", {31'h0, bus.o_wb_stall}, 32'h0);
    mode = 2;
    rst_n = 1'b1;
    base = cyc;
    sync_base = cyc;
    cur_len = L0;

    // Half-high frame: interrupt timing, value, pop.
    wait_until(rdy(0) - 1);
    checkOutput("int_before_f0", {31'h0, o_int}, 32'h0);
    applyStimulus();
    checkOutput("int_rise_f0", {31'h0, o_int}, 32'h1);
    read_reg(1'b0, d);
    checkOutput("f0_data", d, dword(0, 1, exp_sample(fs(0), cur_len)));
    checkOutput("int_after_pop", {31'h0, o_int}, 32'h0);

    mode = 1;
    wait_until(rdy(1)); read_reg(1'b0, d);
    checkOutput("f1_data", d, dword(0, 1, exp_sample(fs(1), cur_len)));
    wait_until(rdy(2)); read_reg(1'b0, d);
    checkOutput("f2_const_high", d, dword(0, 1, exp_sample(fs(2), cur_len)));
    mode = 0;
    wait_until(rdy(3)); read_reg(1'b0, d);
    checkOutput("f3_data", d, dword(0, 1, exp_sample(fs(3), cur_len)));
    wait_until(rdy(4)); read_reg(1'b0, d);
    checkOutput("f4_const_low", d, dword(0, 1, exp_sample(fs(4), cur_len)));
    read_reg(1'b0, d);
    checkOutput("f4_reread", d, dword(0, 0, exp_sample(fs(4), cur_len)));
    checkOutput("int_low_reread", {31'h0, o_int}, 32'h0);

    // Two unread frames set overrun; a clear-write drops it.
    mode = 3;
    wait_until(rdy(6)); read_reg(1'b0, d);
    s6 = exp_sample(fs(6), cur_len);
    checkOutput("overrun_set", d, dword(1, 1, s6));
    write_reg(1'b0, 32'h0002_0000);
    read_reg(1'b0, d);
    checkOutput("overrun_clear", d, dword(0, 0, s6));

    // Pop coinciding with the conversion of the next frame.
    wait_until(rdy(8) - 1);
    mode = 1;
    read_reg(1'b0, d);
    checkOutput("coinc_old", d, dword(0, 1, exp_sample(fs(7), cur_len)));
    checkOutput("coinc_int", {31'h0, o_int}, 32'h1);
    read_reg(1'b0, d);
    checkOutput("coinc_new", d, dword(0, 1, exp_sample(fs(8), cur_len)));

    // Longest frame with a steady high line saturates positive.
    write_reg(1'b1, 32'h8000_FFFF);
    base = cyc;
    cur_len = 65535;
    read_reg(1'b1, d);
    checkOutput("ctrl_len_max", d, 32'h8000_FFFF);
    wait_until(rdy(0)); read_reg(1'b0, d);
    checkOutput("sat_high", d, dword(0, 1, exp_sample(fs(0), cur_len)));

    // Length below the minimum is clamped to 2.
    write_reg(1'b1, 32'h8000_0001);
    base = cyc;
    cur_len = 2;
    read_reg(1'b1, d);
    checkOutput("ctrl_len_min", d, 32'h8000_0002);
    wait_until(rdy(0)); read_reg(1'b0, d);
    checkOutput("len2_sample", d, dword(0, 1, exp_sample(fs(0), cur_len)));

    // Length write while a frame result is pending discards it; then disabled.
    write_reg(1'b1, 32'h0000_0002);
    checkOutput("restart_discard", {31'h0, o_int}, 32'h0);
    w = cyc;
    wait_until(w + 8);
    checkOutput("disabled_idle", {31'h0, o_int}, 32'h0);

    // Mid-frame asynchronous reset with a sample pending.
    mode = 3;
    write_reg(1'b1, 32'h8000_0064);
    base = cyc;
    cur_len = L0;
    wait_until(rdy(0));
    checkOutput("pre_reset_valid", {31'h0, o_int}, 32'h1);
    wait_until(cyc + 30);
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 1'b1;
    applyStimulus();
    checkOutput("pre_reset_ctrl", bus.o_wb_data, 32'h8000_0064);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_int", {31'h0, o_int}, 32'h0);
    checkOutput("async_data", bus.o_wb_data, 32'h0);
    checkOutput("async_ack", {31'h0, bus.o_wb_ack}, 32'h0);
    bus.i_wb_stb = 1'b0;
    repeat (2) applyStimulus();
    rst_n = 1'b1;
    base = cyc;
    sync_base = cyc;
    cur_len = L0;
    wait_until(rdy(0) - 1);
    checkOutput("post_reset_early", {31'h0, o_int}, 32'h0);
    applyStimulus();
    checkOutput("post_reset_first", {31'h0, o_int}, 32'h1);
    read_reg(1'b0, d);
    checkOutput("post_reset_data", d, dword(0, 1, exp_sample(fs(0), cur_len)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
